sd_iofull_fifo: RTL and testbench
=================================

// Module: sd_iofull_fifo
// PURPOSE
//  Parametrised successor to the srdy/drdy full-isolation stage. It is a
//  small FIFO with depth entries, an occupancy count and a synchronous flush.
//  - c_drdy, p_srdy and p_data are driven directly from flops, with no
//    combinational path between the c and p sides.
//  - Sustains one transfer per cycle whenever depth >= 2.
//  - Placed at block and partition boundaries for timing closure and
//    rate decoupling.
// PARAMETERS
//  width  8  data bits per word
//  depth  2  total storage entries, legal 2..64; includes the output head register
//  uwid   $clog2(depth+1)  width of the usage port (derived; do not override)
// PORTS
//  clk     in   1      clock; all state updates on the rising edge
//  reset   in   1      asynchronous, active-high reset
//  flush   in   1      synchronous clear of all stored words
//  c_srdy  in   1      consumer-side word valid
//  c_drdy  out  1      consumer-side ready (registered)
//  c_data  in   width  consumer-side data
//  p_srdy  out  1      producer-side word valid (registered)
//  p_drdy  in   1      producer-side ready
//  p_data  out  width  producer-side data (registered)
//  usage   out  uwid   words held, 0..depth (registered)
// BEHAVIOUR
//  Transfers
//  - Transfer occurs when srdy & drdy are both high at a clock edge.
//  - push = c_srdy & c_drdy; pop = p_srdy & p_drdy.
//  - Words leave in arrival order, with no loss and no duplication.
//  Storage structure
//  - Head register drives p_data/p_srdy; head_vld is identical to p_srdy.
//  - Ring of depth-1 entries with rd_ptr/wr_ptr; both wrap modulo depth-1.
//  Push routing
//  - Goes to the head when the head is empty, or when pop occurs with the
//    ring empty (bypass).
//  - Otherwise goes to ring[wr_ptr].
//  Pop
//  - Reloads the head from ring[rd_ptr] if the ring is non-empty; otherwise
//    head_vld drops.
//  Count and ready
//  - usage_nxt = usage + push - pop; push and pop together leave usage unchanged.
//  - c_drdy <= (usage_nxt < depth).
//  - c_drdy is never high while usage == depth, so the FIFO never overflows.
//  - p_srdy is never high while usage == 0, so the FIFO never underflows.
//  Latency and throughput
//  - Into an empty FIFO: push at edge N gives p_srdy=1 with that word in the
//    cycle after edge N (1-cycle latency).
//  - Full FIFO with pop at edge N: c_drdy=1 in the cycle after N, so there is
//    1 cycle of backpressure latency.
//  - Steady streaming at usage 1 with c_srdy=p_drdy=1 gives one word per cycle.
//  Handshake rules
//  - Once p_srdy is high, p_srdy and p_data hold until pop or flush.
//  - c_drdy may drop without a push occurring.
//  Flush (has priority over every other event)
//  - At the edge: usage<=0, head_vld<=0, pointers<=0, c_drdy<=1.
//  - A push in the flush cycle is discarded.
//  - A pop in the flush cycle is a completed transfer; the receiver keeps
//    that word.
//  Reset
//  - Asynchronous assert gives c_drdy=0, p_srdy=0, p_data=0, usage=0 and
//    both pointers 0.
//  - First edge after deassert sets c_drdy=1.
//  - Reset mid-stream discards all stored words immediately.
//  Other
//  - Ring data is not reset; only the valid/pointer state is reset.
//  - Data and state are never X on outputs after reset.
// TESTING
//  - Reset: assert reset asynchronously mid-cycle -> p_srdy=0, c_drdy=0,
//    usage=0 at once; c_drdy=1 one edge after release.
//  - Stream: depth=2, c_srdy=p_drdy=1 with data 0x00..0xFF -> p_data shows
//    0x00..0xFF in order, 1 cycle late, with no bubbles, usage=1 in steady
//    state.
//  - Fill/drain: depth=4, p_drdy=0, push 0xA1..0xA4 -> usage=4, c_drdy=0;
//    then p_drdy=1 -> A1..A4 in order, c_drdy=1 one cycle after the first pop.
//  - Wrap: depth=3, random srdy/drdy at 50%, 1000 words -> scoreboard match,
//    usage always within 0..3, pointers wrap with no loss.
//  - Flush: usage=3 with push and pop in the same cycle as flush -> popped
//    word counted, pushed word dropped, usage=0, p_srdy=0 on the next cycle.
//  - Holds: p_drdy=0 while p_srdy=1 for 10 cycles -> p_data stable; assertions
//    for no overflow and no underflow hold for the whole run.

Source files
------------

// File: rtl/sd_iofull_fifo_if.sv
// srdy/drdy word channel shared by both sides of sd_iofull_fifo.
// The master drives srdy and data; the slave drives drdy.
interface sd_iofull_fifo_if #(
  parameter int unsigned width = 8
) ();
  logic             srdy;
  logic             drdy;
  logic [width-1:0] data;

  modport master (output srdy, output data, input drdy);
  modport slave  (input srdy, input data, output drdy);
endinterface

// File: rtl/sd_iofull_fifo.sv
// Fully registered srdy/drdy FIFO with a head output register, a ring of depth-1 entries,
// an occupancy count and a synchronous flush. Every c- and p-side output comes from a flop.
module sd_iofull_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 2,
  localparam int unsigned uwid = $clog2(depth + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  sd_iofull_fifo_if.slave  c,
  sd_iofull_fifo_if.master p,
  output logic [uwid-1:0] usage
);

  localparam int unsigned rdepth = depth - 1;
  localparam int unsigned pw     = (rdepth > 1) ? $clog2(rdepth) : 1;

  typedef logic [pw-1:0] ptr_t;

  logic [width-1:0] ring_q [rdepth];
  logic [width-1:0] head_q, head_d;
  logic             head_vld_q, head_vld_d;
  logic             c_drdy_q, c_drdy_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  ptr_t             wr_ptr_q, wr_ptr_d;
  logic [uwid-1:0]  usage_q, usage_d;
  logic             push, pop, ring_empty, ring_we;

  function automatic ptr_t ptr_inc(input ptr_t ptr);
    return (ptr == ptr_t'(rdepth - 1)) ? '0 : ptr + ptr_t'(1);
  endfunction

  assign push = c.srdy & c_drdy_q;
  assign pop  = head_vld_q & p.drdy;
  // The head holds a word whenever usage is non-zero, so the ring only has data above 1.
  assign ring_empty = (usage_q <= uwid'(1));

  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    ring_we    = 1'b0;
    usage_d    = usage_q + uwid'(push) - uwid'(pop);
    if (flush) begin
      head_vld_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      usage_d    = '0;
    end else begin
      if (pop) begin
        if (!ring_empty) begin
          head_d   = ring_q[rd_ptr_q];
          rd_ptr_d = ptr_inc(rd_ptr_q);
          ring_we  = push;
        end else if (push) begin
          head_d = c.data;
        end else begin
          head_vld_d = 1'b0;
        end
      end else if (push) begin
        if (!head_vld_q) begin
          head_d     = c.data;
          head_vld_d = 1'b1;
        end else begin
          ring_we = 1'b1;
        end
      end
      if (ring_we) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
    end
    c_drdy_d = (usage_d < uwid'(depth));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      head_vld_q <= 1'b0;
      c_drdy_q   <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      usage_q    <= '0;
    end else begin
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      c_drdy_q   <= c_drdy_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      usage_q    <= usage_d;
    end
  end

  // Ring storage carries no reset; validity is tracked by usage and the pointers.
  always_ff @(posedge clk) begin
    if (ring_we) begin
      ring_q[wr_ptr_q] <= c.data;
    end
  end

  assign c.drdy = c_drdy_q;
  assign p.srdy = head_vld_q;
  assign p.data = head_q;
  assign usage  = usage_q;

endmodule

// File: tb/tb_sd_iofull_fifo.sv
// Directed bench for sd_iofull_fifo at depths 2, 3 and 4 with hand-computed expectations
// and a queue model for the randomised wrap run.
module tb_sd_iofull_fifo;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       flush;
  logic [1:0] usage2;
  logic [1:0] usage3;
  logic [2:0] usage4;

  int n_checks = 0;
  int n_errors = 0;

  sd_iofull_fifo_if #(.width(8)) c2 ();
  sd_iofull_fifo_if #(.width(8)) p2 ();
  sd_iofull_fifo_if #(.width(8)) c3 ();
  sd_iofull_fifo_if #(.width(8)) p3 ();
  sd_iofull_fifo_if #(.width(8)) c4 ();
  sd_iofull_fifo_if #(.width(8)) p4 ();

  sd_iofull_fifo #(.width(8), .depth(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .c(c2), .p(p2), .usage(usage2)
  );
  sd_iofull_fifo #(.width(8), .depth(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush), .c(c3), .p(p3), .usage(usage3)
  );
  sd_iofull_fifo #(.width(8), .depth(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .c(c4), .p(p4), .usage(usage4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Overflow / underflow watch on every instance for the whole run.
  always @(negedge clk) begin
    check("ovf2", 32'(c2.drdy && usage2 == 2'd2), 32'd0);
    check("unf2", 32'(p2.srdy && usage2 == 2'd0), 32'd0);
    check("ovf3", 32'(c3.drdy && usage3 == 2'd3), 32'd0);
    check("unf3", 32'(p3.srdy && usage3 == 2'd0), 32'd0);
    check("ovf4", 32'(c4.drdy && usage4 == 3'd4), 32'd0);
    check("unf4", 32'(p4.srdy && usage4 == 3'd0), 32'd0);
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_word;
    logic       do_push, do_pop;
    int         pushed, popped, cycles;

    flush   = 1'b0;
    c2.srdy = 1'b0; c2.data = '0; p2.drdy = 1'b0;
    c3.srdy = 1'b0; c3.data = '0; p3.drdy = 1'b0;
    c4.srdy = 1'b0; c4.data = '0; p4.drdy = 1'b0;

    // Reset state and release
    #12;
    check("rst_c_drdy", 32'(c4.drdy), 32'd0);
    check("rst_p_srdy", 32'(p4.srdy), 32'd0);
    check("rst_p_data", 32'(p4.data), 32'd0);
    check("rst_usage", 32'(usage4), 32'd0);
    reset = 1'b0;
    #1;
    check("rel_c_drdy_pre", 32'(c2.drdy), 32'd0);
    tick();
    check("rel_c_drdy2", 32'(c2.drdy), 32'd1);
    check("rel_c_drdy3", 32'(c3.drdy), 32'd1);
    check("rel_c_drdy4", 32'(c4.drdy), 32'd1);

    // Streaming through depth 2: one word per cycle, one cycle late
    c2.srdy = 1'b1;
    p2.drdy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      c2.data = 8'(i);
      tick();
      check("stream_data", 32'(p2.data), 32'(i));
      check("stream_srdy", 32'(p2.srdy), 32'd1);
      check("stream_usage", 32'(usage2), 32'd1);
      check("stream_c_drdy", 32'(c2.drdy), 32'd1);
    end
    c2.srdy = 1'b0;
    tick();
    check("stream_end_srdy", 32'(p2.srdy), 32'd0);
    check("stream_end_usage", 32'(usage2), 32'd0);
    p2.drdy = 1'b0;

    // Fill and drain depth 4
    c4.srdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c4.data = 8'hA1 + 8'(i);
      tick();
      check("fill_usage", 32'(usage4), 32'(i + 1));
      check("fill_c_drdy", 32'(c4.drdy), (i < 3) ? 32'd1 : 32'd0);
      check("fill_head", 32'(p4.data), 32'hA1);
    end
    c4.srdy = 1'b0;
    c4.data = 8'h00;
    p4.drdy = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("drain_data", 32'(p4.data), 32'hA1 + 32'(i));
      check("drain_usage", 32'(usage4), 32'(4 - i));
      check("drain_c_drdy", 32'(c4.drdy), 32'd1);
    end
    tick();
    check("drain_end_srdy", 32'(p4.srdy), 32'd0);
    check("drain_end_usage", 32'(usage4), 32'd0);
    p4.drdy = 1'b0;

    // Hold while the receiver stalls
    c4.srdy = 1'b1;
    c4.data = 8'h5C;
    tick();
    c4.srdy = 1'b0;
    c4.data = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_data", 32'(p4.data), 32'h5C);
      check("hold_srdy", 32'(p4.srdy), 32'd1);
    end
    p4.drdy = 1'b1;
    tick();
    check("hold_release_usage", 32'(usage4), 32'd0);
    p4.drdy = 1'b0;

    // Flush at usage 3 with push and pop in the same cycle
    c4.srdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c4.data = 8'h11 * 8'(i + 1);
      tick();
    end
    check("flush_pre_usage", 32'(usage4), 32'd3);
    c4.data = 8'h44;
    p4.drdy = 1'b1;
    flush   = 1'b1;
    check("flush_popped_word", 32'(p4.data), 32'h11);
    check("flush_popped_srdy", 32'(p4.srdy), 32'd1);
    tick();
    flush   = 1'b0;
    c4.srdy = 1'b0;
    p4.drdy = 1'b0;
    check("flush_usage", 32'(usage4), 32'd0);
    check("flush_p_srdy", 32'(p4.srdy), 32'd0);
    check("flush_c_drdy", 32'(c4.drdy), 32'd1);
    c4.srdy = 1'b1;
    c4.data = 8'h55;
    tick();
    c4.data = 8'h66;
    tick();
    c4.srdy = 1'b0;
    check("post_flush_head", 32'(p4.data), 32'h55);
    check("post_flush_usage", 32'(usage4), 32'd2);
    p4.drdy = 1'b1;
    tick();
    check("post_flush_next", 32'(p4.data), 32'h66);
    tick();
    check("post_flush_empty", 32'(usage4), 32'd0);
    p4.drdy = 1'b0;

    // Random handshakes through depth 3 against a queue model
    pushed  = 0;
    popped  = 0;
    cycles  = 0;
    c3.data = 8'd5;
    while (popped < 1000 && cycles < 20000) begin
      c3.srdy = (pushed < 1000) && ($urandom_range(0, 1) == 1);
      p3.drdy = ($urandom_range(0, 1) == 1);
      do_push = c3.srdy & c3.drdy;
      do_pop  = p3.srdy & p3.drdy;
      if (do_pop) begin
        if (q.size() == 0) begin
          check("wrap_underflow", 32'd1, 32'd0);
        end else begin
          exp_word = q.pop_front();
          check("wrap_data", 32'(p3.data), 32'(exp_word));
        end
        popped++;
      end
      if (do_push) begin
        q.push_back(c3.data);
        pushed++;
      end
      tick();
      cycles++;
      if (do_push) c3.data = 8'(pushed * 37 + 5);
      check("wrap_usage", 32'(usage3), 32'(q.size()));
    end
    check("wrap_done", 32'(popped), 32'd1000);
    c3.srdy = 1'b0;
    p3.drdy = 1'b0;

    // Reset asserted mid-stream discards stored words at once
    c3.srdy = 1'b1;
    c3.data = 8'h77;
    tick();
    tick();
    c3.srdy = 1'b0;
    check("mid_pre_usage", 32'(usage3), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_usage", 32'(usage3), 32'd0);
    check("mid_rst_p_srdy", 32'(p3.srdy), 32'd0);
    check("mid_rst_c_drdy", 32'(c3.drdy), 32'd0);
    check("mid_rst_p_data", 32'(p3.data), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rel_c_drdy_pre", 32'(c3.drdy), 32'd0);
    tick();
    check("mid_rel_c_drdy", 32'(c3.drdy), 32'd1);
    check("mid_rel_p_srdy", 32'(p3.srdy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
